// File: rtl/nn_pkg.sv
// Shared definitions for the neural-network datapath blocks.
//   seq_state_t : states of the per-neuron dot-product sequencer
//   acc_width   : accumulator width that holds max_len full-scale products
//   addr_width  : operand-memory address width (never below 1 bit)
package nn_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FETCH,
        DRAIN0,
        DRAIN1,
        CAPTURE,
        DONE
    } seq_state_t;

    // Also used when sizing the MAC itself, so the two always agree.
    function automatic int acc_width(input int width, input int max_len);
        return 2 * width + $clog2(max_len);
    endfunction

    function automatic int addr_width(input int max_len);
        return (max_len > 1) ? $clog2(max_len) : 1;
    endfunction

endpackage

// File: rtl/mac_sequencer_if.sv
// Bundle of every non-clock signal between the dot-product sequencer and
// its surroundings (scheduler request, operand memories, MAC, result port).
//   slave  : the sequencer's view
//   master : the environment's view (scheduler + memories + MAC)
interface mac_sequencer_if #(
    parameter int WIDTH   = 8,
    parameter int MAX_LEN = 16
);
    import nn_pkg::*;

    localparam int ADDR_W = addr_width(MAX_LEN);
    localparam int LEN_W  = $clog2(MAX_LEN + 1);
    localparam int ACC_W  = acc_width(WIDTH, MAX_LEN);

    logic              start;
    logic [LEN_W-1:0]  length;
    logic              busy;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [WIDTH-1:0]  mem_a;
    logic [WIDTH-1:0]  mem_b;
    logic [WIDTH-1:0]  mac_a;
    logic [WIDTH-1:0]  mac_b;
    logic              mac_enable;
    logic              mac_clear;
    logic [ACC_W-1:0]  acc_in;
    logic [ACC_W-1:0]  result;
    logic              result_valid;
    logic              result_ready;

    modport slave (
        input  start, length, mem_a, mem_b, acc_in, result_ready,
        output busy, rd_en, rd_addr, mac_a, mac_b, mac_enable, mac_clear,
               result, result_valid
    );

    modport master (
        output start, length, mem_a, mem_b, acc_in, result_ready,
        input  busy, rd_en, rd_addr, mac_a, mac_b, mac_enable, mac_clear,
               result, result_valid
    );

endinterface

// File: rtl/mac_addr_counter.sv
// Operand read-address counter.
//   clk, reset : clock, async active-high reset (count -> 0)
//   load       : restart the count at address 0
//   inc        : advance to the next address
//   last       : final address of the current run
//   count      : current read address
//   tc         : terminal count, high while count == last
module mac_addr_counter #(
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              inc,
    input  logic [ADDR_W-1:0] last,
    output logic [ADDR_W-1:0] count,
    output logic              tc
);

    // NOTE: sequential state is updated with <= so every flop samples the
    // pre-edge values of its neighbours; = here would create order races.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            count <= '0;
        else if (load)
            count <= '0;
        else if (inc)
            count <= count + 1'b1;
    end

    assign tc = (count == last);

endmodule

// File: rtl/mac_sequencer.sv
// Per-neuron dot-product sequencer: clears the MAC, streams L operand pairs
// from the memories into it, drains the MAC's product register, captures the
// accumulator and offers it on a valid/ready port.
//   clk   : clock
//   reset : async active-high reset, returns to IDLE with all outputs 0
//   bus   : mac_sequencer_if.slave (request, memory, MAC and result signals)
module mac_sequencer
    import nn_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int MAX_LEN = 16
) (
    input  logic           clk,
    input  logic           reset,
    mac_sequencer_if.slave bus
);

    localparam int ADDR_W = addr_width(MAX_LEN);
    localparam int LEN_W  = $clog2(MAX_LEN + 1);

    seq_state_t        state_q, state_d;
    logic              len_zero_q;
    logic [ADDR_W-1:0] last_q;
    logic [LEN_W-1:0]  clamped_len;
    logic              op_valid_q;
    logic [ADDR_W-1:0] count;
    logic              tc;
    logic              cnt_load;
    logic              cnt_inc;

    assign clamped_len = (bus.length > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : bus.length;

    // The counter sits on the last address when FETCH ends, so rd_addr comes
    // straight from its flops.
    assign cnt_load = (state_q == CLEAR);
    assign cnt_inc  = (state_q == FETCH) && !tc;

    mac_addr_counter #(.ADDR_W(ADDR_W)) u_addr_counter (
        .clk   (clk),
        .reset (reset),
        .load  (cnt_load),
        .inc   (cnt_inc),
        .last  (last_q),
        .count (count),
        .tc    (tc)
    );

    // NOTE: state_d gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.start) state_d = CLEAR;
            CLEAR:   state_d = len_zero_q ? CAPTURE : FETCH;
            FETCH:   if (tc) state_d = DRAIN0;
            DRAIN0:  state_d = DRAIN1;
            DRAIN1:  state_d = CAPTURE;
            CAPTURE: state_d = DONE;
            DONE:    if (bus.result_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            len_zero_q <= 1'b0;
            last_q     <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && bus.start) begin
                len_zero_q <= (clamped_len == '0);
                last_q     <= ADDR_W'(clamped_len - 1'b1);
            end
        end
    end

    // Outputs are decoded from state_d so they are flop outputs that line up
    // with the state they belong to. mac_clear in particular drives the MAC's
    // async reset and must be glitch-free.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.busy         <= 1'b0;
            bus.rd_en        <= 1'b0;
            bus.mac_clear    <= 1'b0;
            bus.mac_enable   <= 1'b0;
            bus.result_valid <= 1'b0;
            bus.result       <= '0;
            op_valid_q       <= 1'b0;
        end else begin
            bus.busy         <= (state_d != IDLE);
            bus.rd_en        <= (state_d == FETCH);
            bus.mac_clear    <= (state_d == CLEAR);
            op_valid_q       <= bus.rd_en;
            // Enabled while read data is arriving, plus the DRAIN1 flush.
            bus.mac_enable   <= bus.rd_en || (state_d == DRAIN1);
            bus.result_valid <= (state_d == DONE);
            if (state_q == CAPTURE)
                bus.result <= bus.acc_in;
        end
    end

    assign bus.rd_addr = count;

    // Memory data is already a register output one cycle after the address,
    // so it is only gated here; another flop would break the k+1 alignment.
    assign bus.mac_a = op_valid_q ? bus.mem_a : '0;
    assign bus.mac_b = op_valid_q ? bus.mem_b : '0;

endmodule

// File: tb/tb_mac_sequencer.sv
// Self-checking bench for mac_sequencer. Models the operand memories
// (1-cycle synchronous read) and a MAC with one product register, drives
// randomized dot products, and checks results against a queue of
// expectations computed directly as sum(a[i]*b[i]) over min(length,MAX_LEN).
module tb_mac_sequencer;
    import nn_pkg::*;

    localparam int WIDTH   = 8;
    localparam int MAX_LEN = 16;
    localparam int ACC_W   = acc_width(WIDTH, MAX_LEN);
    localparam int LEN_W   = $clog2(MAX_LEN + 1);

    typedef struct {
        longint unsigned sum;
        int              lat;
        int              len;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mac_sequencer_if #(.WIDTH(WIDTH), .MAX_LEN(MAX_LEN)) bus ();

    mac_sequencer #(.WIDTH(WIDTH), .MAX_LEN(MAX_LEN)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Operand memories
    logic [WIDTH-1:0] ma [MAX_LEN];
    logic [WIDTH-1:0] mb [MAX_LEN];

    always @(posedge clk) begin
        if (bus.rd_en) begin
            bus.mem_a <= ma[bus.rd_addr];
            bus.mem_b <= mb[bus.rd_addr];
        end
    end

    // MAC: product register feeding the accumulator, async clear
    logic [ACC_W-1:0]   acc;
    logic [2*WIDTH-1:0] prod;
    logic               mac_rst;
    assign mac_rst    = reset | bus.mac_clear;
    assign bus.acc_in = acc;

    always @(posedge clk or posedge mac_rst) begin
        if (mac_rst) begin
            acc  <= '0;
            prod <= '0;
        end else if (bus.mac_enable) begin
            prod <= bus.mac_a * bus.mac_b;
            acc  <= acc + ACC_W'(prod);
        end
    end

    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t sb[$];
    int   cyc      = 0;

    task automatic check(input string name, input longint unsigned actual,
                         input longint unsigned expected);
        n_checks++;
        if (actual == expected)
            n_pass++;
        else
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    endtask

    // Monitor: samples 1 time unit after each rising edge
    initial begin
        int   e0 = 0;
        int   nreads = 0;
        int   nclears = 0;
        bit   in_run = 0;
        logic prev_valid = 1'b0;
        logic prev_busy = 1'b0;
        logic [ACC_W-1:0] held = '0;
        exp_t cur;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (reset) begin
                in_run     = 0;
                prev_valid = 1'b0;
                prev_busy  = 1'b0;
                continue;
            end
            if (bus.busy && !prev_busy) begin
                in_run  = 1;
                e0      = cyc;
                nreads  = 0;
                nclears = 0;
            end
            if (in_run) begin
                if (bus.rd_en) begin
                    check("rd_addr order", bus.rd_addr, nreads);
                    nreads++;
                end
                if (bus.mac_clear) nclears++;
            end
            if (bus.result_valid && !prev_valid) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected result: got %0d with no pending request", bus.result);
                end else begin
                    cur = sb.pop_front();
                    check("result", bus.result, cur.sum);
                    check("valid latency", cyc - e0, cur.lat);
                    check("read count", nreads, cur.len);
                    check("mac_clear pulses", nclears, 1);
                    held = bus.result;
                end
            end else if (bus.result_valid) begin
                check("result stable", bus.result, held);
            end
            if (prev_valid && bus.result_ready) begin
                check("busy after handshake", bus.busy, 0);
                check("valid after handshake", bus.result_valid, 0);
                in_run = 0;
            end
            prev_valid = bus.result_valid;
            prev_busy  = bus.busy;
        end
    end

    function automatic exp_t model(input int len);
        exp_t e;
        int   l;
        l     = (len > MAX_LEN) ? MAX_LEN : len;
        e.sum = 0;
        for (int i = 0; i < l; i++)
            e.sum += longint'(ma[i]) * longint'(mb[i]);
        e.len = l;
        e.lat = (l == 0) ? 2 : l + 4;
        return e;
    endfunction

    task automatic fill_random();
        for (int i = 0; i < MAX_LEN; i++) begin
            ma[i] = WIDTH'($urandom);
            mb[i] = WIDTH'($urandom);
        end
    endtask

    // One dot product: issue start, wait for valid (bounded), stall `hold`
    // cycles, then handshake. With `noisy`, start/result_ready toggle
    // randomly while the sequencer is busy.
    task automatic run_dp(input int len, input int hold, input bit noisy);
        bit got;
        sb.push_back(model(len));
        @(negedge clk);
        bus.start  = 1'b1;
        bus.length = LEN_W'(len);
        @(negedge clk);
        bus.start  = 1'b0;
        bus.length = LEN_W'($urandom);
        got = 0;
        for (int n = 0; n < 200; n++) begin
            if (bus.result_valid) begin
                got = 1;
                break;
            end
            bus.result_ready = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.start        = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
            @(negedge clk);
        end
        if (!got) begin
            n_checks++;
            $display("FAIL valid timeout: result_valid not seen within 200 cycles (len %0d)", len);
            sb.delete();
            bus.start        = 1'b0;
            bus.result_ready = 1'b0;
            return;
        end
        for (int h = 0; h < hold; h++) begin
            bus.result_ready = 1'b0;
            bus.start        = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.length       = LEN_W'($urandom);
            @(negedge clk);
        end
        bus.result_ready = 1'b1;
        bus.start        = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
        @(negedge clk);
        bus.result_ready = 1'b0;
        bus.start        = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " busy"}, bus.busy, 0);
        check({tag, " rd_en"}, bus.rd_en, 0);
        check({tag, " rd_addr"}, bus.rd_addr, 0);
        check({tag, " mac_a"}, bus.mac_a, 0);
        check({tag, " mac_b"}, bus.mac_b, 0);
        check({tag, " mac_enable"}, bus.mac_enable, 0);
        check({tag, " mac_clear"}, bus.mac_clear, 0);
        check({tag, " result"}, bus.result, 0);
        check({tag, " result_valid"}, bus.result_valid, 0);
    endtask

    initial begin
        bit hit;
        bus.start        = 1'b0;
        bus.length       = '0;
        bus.result_ready = 1'b0;
        reset            = 1'b1;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;
        @(negedge clk);
        check_all_zero("idle");

        // a = 1..4, b = 2
        for (int i = 0; i < MAX_LEN; i++) begin
            ma[i] = (i < 4) ? WIDTH'(i + 1) : 8'd0;
            mb[i] = (i < 4) ? 8'd2 : 8'd0;
        end
        run_dp(4, 0, 0);

        // Full-scale operands, clamped length
        for (int i = 0; i < MAX_LEN; i++) begin
            ma[i] = 8'hFF;
            mb[i] = 8'hFF;
        end
        run_dp(16, 1, 0);
        run_dp(20, 0, 0);
        run_dp(0, 0, 0);

        // Stall in DONE with start pulses
        fill_random();
        run_dp(7, 5, 1);

        // Reset during FETCH cycle 2
        fill_random();
        sb.push_back(model(8));
        @(negedge clk);
        bus.start  = 1'b1;
        bus.length = LEN_W'(8);
        @(negedge clk);
        bus.start = 1'b0;
        hit = 0;
        for (int n = 0; n < 20; n++) begin
            if (bus.rd_en && bus.rd_addr == 2) begin
                hit = 1;
                break;
            end
            @(negedge clk);
        end
        check("reached fetch cycle 2", hit, 1);
        reset = 1'b1;
        #1;
        check_all_zero("mid-fetch reset");
        sb.delete();
        @(negedge clk);
        reset = 1'b0;
        run_dp(3, 0, 0);

        // Back-to-back runs on different data
        fill_random();
        run_dp(5, 0, 0);
        fill_random();
        run_dp(9, 0, 0);

        // Randomized runs
        for (int r = 0; r < 20; r++) begin
            fill_random();
            run_dp($urandom_range(0, 20), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        repeat (3) @(negedge clk);
        check("scoreboard drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
